// File: rtl/video_pattern_gen.sv
// Raster timing generator plus test-pattern source driving a vsync/href/de/data
// video stream. Timing, channel count and sync polarity are parameters; four
// run-time patterns (bars, gradient, checker, frame-id) are selected by mode.
// Optional CRC-16-CCITT over the active pixels: define VIDEO_PATTERN_GEN_CRC_EN.
//
// state | meaning
// IDLE  | counters parked at 0,0, outputs inactive, waiting for en
// RUN   | raster counters advancing; frames end only at the last BP clock
module video_pattern_gen #(
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_ACTIVE   = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20,
  parameter int CHANNELS   = 3,
  parameter int CHECK_SIZE = 32,
  parameter int SYNC_POL   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [1:0]              mode,
  output logic                    video_vsync,
  output logic                    video_href,
  output logic                    video_de,
  output logic [8*CHANNELS-1:0]   video_data,
  output logic [10:0]             x_pos,
  output logic [10:0]             y_pos,
  output logic [15:0]             frame_cnt
`ifdef VIDEO_PATTERN_GEN_CRC_EN
  ,
  output logic [15:0]             crc_out,
  output logic                    crc_valid
`endif
);

  localparam int DW = 8 * CHANNELS;
  localparam logic [15:0] HA    = 16'(H_ACTIVE);
  localparam logic [15:0] VA    = 16'(V_ACTIVE);
  localparam logic [15:0] H_END = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_END = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] HS0   = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS1   = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [15:0] VS0   = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS1   = 16'(V_ACTIVE + V_FP + V_SYNC - 1);
  // Bar width floors at 1 so tiny rasters still decode (idx then clamps to 7).
  localparam logic [15:0] BAR_W  = 16'((H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8);
  localparam int          CS_LOG = $clog2(CHECK_SIZE);
  localparam logic        ACT    = (SYNC_POL != 0);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_next;
  logic [15:0]   h_cnt, v_cnt;
  logic [1:0]    mode_q;
  logic          run, frame_end, de_c, href_c, vsync_c;
  logic [15:0]   bar_q;
  logic [2:0]    bar_idx;
  logic [7:0]    grad, chk;
  logic [DW-1:0] pix_c;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and raster decode of the current counter position.
  always_comb begin
    state_next = state;
    run        = (state == RUN);
    frame_end  = run && (h_cnt == H_END) && (v_cnt == V_END);
    de_c       = run && (h_cnt < HA) && (v_cnt < VA);
    href_c     = run && (h_cnt >= HS0) && (h_cnt <= HS1);
    vsync_c    = run && (v_cnt >= VS0) && (v_cnt <= VS1);
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (frame_end && !en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bar_q   = h_cnt / BAR_W;
  assign bar_idx = (bar_q > 16'd7) ? 3'd7 : bar_q[2:0];
  assign grad    = h_cnt[7:0] + v_cnt[7:0];
  assign chk     = (h_cnt[CS_LOG] ^ v_cnt[CS_LOG]) ? 8'hFF : 8'h00;

  // Pattern mux, one channel at a time so absent channels simply drop out.
  always_comb begin
    pix_c = '0;
    if (de_c) begin
      for (int c = 0; c < CHANNELS; c++) begin
        case (mode_q)
          2'd0: pix_c[8*c +: 8] = (c == 0) ? {8{~bar_idx[0]}} :
                                  (c == 1) ? {8{~bar_idx[2]}} :
                                  (c == 2) ? {8{~bar_idx[1]}} : 8'h00;
          2'd1: pix_c[8*c +: 8] = grad;
          2'd2: pix_c[8*c +: 8] = chk;
          default: pix_c[8*c +: 8] = (c == 0) ? h_cnt[7:0] :
                                     (c == 1) ? v_cnt[7:0] :
                                     (c == 2) ? frame_cnt[7:0] : 8'h00;
        endcase
      end
    end
  end

  // Raster counters, frame counter and frame-start mode latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      mode_q    <= '0;
      frame_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
      if (en) mode_q <= mode;
    end else if (frame_end) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= frame_cnt + 16'd1;
      if (en) mode_q <= mode;
    end else if (h_cnt == H_END) begin
      h_cnt <= '0;
      v_cnt <= v_cnt + 16'd1;
    end else begin
      h_cnt <= h_cnt + 16'd1;
    end
  end

  // Registered video outputs, one clock behind the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      video_vsync <= ~ACT;
      video_href  <= ~ACT;
      video_de    <= 1'b0;
      video_data  <= '0;
      x_pos       <= '0;
      y_pos       <= '0;
    end else begin
      video_vsync <= vsync_c ? ACT : ~ACT;
      video_href  <= href_c ? ACT : ~ACT;
      video_de    <= de_c;
      video_data  <= pix_c;
      x_pos       <= de_c ? h_cnt[10:0] : 11'd0;
      y_pos       <= de_c ? v_cnt[10:0] : 11'd0;
    end
  end

`ifdef VIDEO_PATTERN_GEN_CRC_EN
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [DW-1:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  logic [15:0] crc_acc;

  // Frame CRC: seeded while idle and at each frame end, published on the last BP clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_acc   <= 16'hFFFF;
      crc_out   <= '0;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      if (!run) begin
        crc_acc <= 16'hFFFF;
      end else if (frame_end) begin
        crc_out   <= crc_acc;
        crc_valid <= 1'b1;
        crc_acc   <= 16'hFFFF;
      end else if (de_c) begin
        crc_acc <= crc_step(crc_acc, pix_c);
      end
    end
  end
`endif

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen on a 16x4 raster (22x7 total, 154 clocks/frame).
// Expected pixels are queued per frame; a negedge monitor pops and compares.
module tb_video_pattern_gen;
  localparam int HA = 16, HFP = 2, HSY = 2, HBP = 2;
  localparam int VA = 4,  VFP = 1, VSY = 1, VBP = 1;
  localparam int CS = 4;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [1:0]  mode;
  logic        video_vsync, video_href, video_de;
  logic [23:0] video_data;
  logic [10:0] x_pos, y_pos;
  logic [15:0] frame_cnt;
`ifdef VIDEO_PATTERN_GEN_CRC_EN
  logic [15:0] crc_out;
  logic        crc_valid;
  logic [15:0] crc_q[$];
  int          crc_pulses = 0;
`endif

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .CHANNELS(3), .CHECK_SIZE(CS), .SYNC_POL(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .video_vsync(video_vsync), .video_href(video_href), .video_de(video_de),
    .video_data(video_data), .x_pos(x_pos), .y_pos(y_pos),
    .frame_cnt(frame_cnt)
`ifdef VIDEO_PATTERN_GEN_CRC_EN
    , .crc_out(crc_out), .crc_valid(crc_valid)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [23:0] d;
    logic [10:0] x;
    logic [10:0] y;
  } pix_t;

  pix_t        exp_q[$];
  pix_t        mon_p;
  logic [23:0] bars[8];
  int          tests = 0, errors = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    errors++;
    $display("FAIL %s: got timeout, want event (t=%0d)", name, cyc);
  endtask

  function automatic logic [23:0] model_pix(input int m, input int x, input int y, input int fc);
    logic [7:0] g;
    case (m)
      0:       return bars[(x / 2 > 7) ? 7 : x / 2];
      1:       begin g = 8'(x + y); return {g, g, g}; end
      2:       return (((x / CS) ^ (y / CS)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
      default: return {8'(fc), 8'(y), 8'(x)};
    endcase
  endfunction

`ifdef VIDEO_PATTERN_GEN_CRC_EN
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      if (r[15] != d[i]) r = (r << 1) ^ 16'h1021;
      else               r = r << 1;
    end
    return r;
  endfunction
`endif

  // Queue the first n pixels of a frame drawn in mode m while frame_cnt == fc.
  task automatic push_frame(input int m, input int fc, input int n);
    int   k;
    pix_t p;
`ifdef VIDEO_PATTERN_GEN_CRC_EN
    logic [15:0] c = 16'hFFFF;
`endif
    k = 0;
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        if (k < n) begin
          p.d = model_pix(m, x, y, fc);
          p.x = 11'(x);
          p.y = 11'(y);
          exp_q.push_back(p);
`ifdef VIDEO_PATTERN_GEN_CRC_EN
          c = crc_model(c, p.d);
`endif
          k++;
        end
      end
    end
`ifdef VIDEO_PATTERN_GEN_CRC_EN
    if (n == HA * VA) crc_q.push_back(c);
`endif
  endtask

  task automatic wait_pixel(input int x, input int y, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (video_de && x_pos == 11'(x) && y_pos == 11'(y)) ok = 1'b1;
    end
    if (!ok) timeout(name);
  endtask

  task automatic wait_fc(input int n);
    for (int i = 0; i < 400; i++) begin
      if (frame_cnt == 16'(n)) break;
      @(negedge clk);
    end
    check("frame_cnt", 64'(frame_cnt), 64'(n));
  endtask

  // Monitor: every active pixel must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (video_de) begin
        if (exp_q.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL unexpected_pixel: got x=%0d y=%0d, want no pixel", x_pos, y_pos);
        end else begin
          mon_p = exp_q.pop_front();
          check("pixel", {video_data, x_pos, y_pos}, {mon_p.d, mon_p.x, mon_p.y});
        end
      end else begin
        check("blank", {video_data, x_pos, y_pos}, 64'd0);
      end
`ifdef VIDEO_PATTERN_GEN_CRC_EN
      if (crc_valid) begin
        crc_pulses++;
        if (crc_q.size() == 0) check("crc_unexpected", 64'(crc_out), 64'hDEAD_0000);
        else                   check("crc", 64'(crc_out), 64'(crc_q.pop_front()));
      end
`endif
    end
  end

  initial begin
    int t0, t1, t2, n, act_cnt;
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
    rst = 1'b1; en = 1'b0; mode = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    check("rst_vsync", 64'(video_vsync), 64'd0);
    check("rst_href",  64'(video_href),  64'd0);
    check("rst_de",    64'(video_de),    64'd0);
    check("rst_data",  64'(video_data),  64'd0);
    check("rst_xy",    {x_pos, y_pos},   64'd0);
    check("rst_fc",    64'(frame_cnt),   64'd0);

    // Idle with en low: nothing moves.
    rst = 1'b0;
    act_cnt = 0;
    repeat (10) begin @(negedge clk); if (video_de || video_href || video_vsync) act_cnt++; end
    check("idle_quiet", 64'(act_cnt), 64'd0);

    // Reset mid-frame at pixel 7 of line 2: only 40 pixels come out.
    push_frame(0, 0, 40);
    en = 1'b1;
    wait_pixel(7, 2, "rst_point");
    rst = 1'b1;
    @(negedge clk);
    check("midrst_de",   64'(video_de),   64'd0);
    check("midrst_data", 64'(video_data), 64'd0);
    check("midrst_fc",   64'(frame_cnt),  64'd0);
    push_frame(0, 0, 64);
    rst = 1'b0;

    // Frame 1 (bars): raster timing.
    wait_pixel(0, 0, "f1_start");
    t0 = cyc;
    t1 = t0;
    for (int i = 0; i < 100 && !video_href; i++) begin @(negedge clk); t1 = cyc; end
    check("href_delay", 64'(t1 - t0), 64'd18);
    n = 0;
    for (int i = 0; i < 50 && video_href; i++) begin n++; @(negedge clk); end
    check("href_width", 64'(n), 64'd2);
    mode = 2'd1;
    push_frame(1, 1, 64);
    wait_fc(1);

    // Frame 2 (gradient): frame period.
    wait_pixel(0, 0, "f2_start");
    t2 = cyc;
    check("frame_period", 64'(t2 - t0), 64'd154);
    mode = 2'd3;
    push_frame(3, 2, 64);
    wait_fc(2);

    // Frame 3 (frame-id), mode switched to checker mid-frame.
    wait_pixel(5, 2, "f3_pix");
    check("frame_id_pixel", 64'(video_data), 64'h020205);
    mode = 2'd2;
    push_frame(2, 3, 64);
    wait_fc(3);

    // Frame 4 (checker), en dropped on line 1: frame still completes.
    wait_pixel(0, 1, "f4_line1");
    en = 1'b0;
    wait_fc(4);
    act_cnt = 0;
    repeat (300) begin @(negedge clk); if (video_de || video_href || video_vsync) act_cnt++; end
    check("stopped_quiet", 64'(act_cnt), 64'd0);
    check("stopped_fc", 64'(frame_cnt), 64'd4);

    // Restart: a single fresh frame from 0,0.
    mode = 2'd1;
    push_frame(1, 4, 64);
    en = 1'b1;
    wait_pixel(0, 0, "f5_start");
    en = 1'b0;
    wait_fc(5);
    repeat (20) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
`ifdef VIDEO_PATTERN_GEN_CRC_EN
    check("crc_drained", 64'(crc_q.size()), 64'd0);
    check("crc_pulses", 64'(crc_pulses), 64'd5);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
Parametrised, synthesizable video source. It combines a raster timing generator and a test-pattern generator, and drives the same vsync/href/de/data stream as the cmos/video ports of video_stiching_top. It is the successor to the fixed 1280x720 bitmap-driven camera model. Timing, pixel width and channel count are generic, and four run-time pattern modes are selectable. It drives stitching-pipeline benches and on-board bring-up without a camera.

Parameters:
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch (clocks)
H_SYNC, 40, horizontal sync width
H_BP, 220, horizontal back porch
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vertical sync width
V_BP, 20, vertical back porch
CHANNELS, 3, 8-bit colour channels per pixel (1..4); DATA_WIDTH = 8*CHANNELS
CHECK_SIZE, 32, checkerboard square edge in pixels (power of 2)
SYNC_POL, 1, 1 = vsync/href active-high, 0 = active-low

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
en  in  1  run request
mode  in  2  pattern select, sampled at frame start only
video_vsync  out  1  vertical sync
video_href  out  1  horizontal sync
video_de  out  1  active-pixel strobe
video_data  out  8*CHANNELS  pixel; channel 0 = LSBs
x_pos  out  11  active column of current pixel (0 when de=0)
y_pos  out  11  active line of current pixel (0 when de=0)
frame_cnt  out  16  completed frames, wraps at 0xFFFF

Behaviour:
- Reset: h_cnt=v_cnt=0; state IDLE; video_de=0; video_data, x_pos, y_pos, frame_cnt = 0; vsync/href at inactive level (~SYNC_POL).
- Line layout: h_cnt 0..H_ACTIVE-1 active, then FP, SYNC, BP. H_TOTAL = sum. Frame layout is the same with v_cnt; V_TOTAL = sum.
- href is active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. vsync is active over the whole lines in the matching V range. de = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
- All outputs are registered: one clock of latency from the counter state.
- FSM:
  - IDLE -> RUN when en=1. Counters start at 0,0; mode is latched.
  - RUN: h_cnt increments each clock. At H_TOTAL-1 it wraps and v_cnt increments. At v_cnt=V_TOTAL-1 and h_cnt=H_TOTAL-1, frame_cnt++.
    - If en=1 at that point: continue from 0,0 and re-latch mode.
    - If en=0: go to IDLE, counters return to 0, outputs inactive.
- en deasserted mid-frame: the current frame always completes; no truncated frames.
- mode changes mid-frame have no effect until the next frame start.
- Patterns, with x=h_cnt and y=v_cnt during active:
  - 0 colour bars: idx = min(x/(H_ACTIVE/8), 7). ch2 = {8{~idx[1]}}, ch1 = {8{~idx[2]}}, ch0 = {8{~idx[0]}}. Order: white, yellow, cyan, green, magenta, red, blue, black. Channel 3 = 0; missing channels are dropped.
  - 1 gradient: every channel = x[7:0] + y[7:0] (mod 256).
  - 2 checker: every channel = ((x/CHECK_SIZE) ^ (y/CHECK_SIZE))[0] ? 8'hFF : 8'h00.
  - 3 frame-id: ch0 = x[7:0], ch1 = y[7:0], ch2 = frame_cnt[7:0], ch3 = 0.
- video_data = 0 whenever de=0.
- Reset mid-frame: on the next clock all outputs are at reset values and state is IDLE; frame_cnt is not incremented.
- Illegal parameters (H_ACTIVE not divisible by 8 in mode 0) clamp as defined by the min().

Optional Feature:
VIDEO_PATTERN_GEN_CRC_EN.
- Defined: adds ports crc_out (out, 16) and crc_valid (out, 1).
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) runs over every active pixel, whole DATA_WIDTH word per clock.
  - Seeded at frame start.
  - At the last BP clock of each frame, crc_out holds the result and crc_valid pulses for 1 clock.
  - Both are reset to 0.
- Undefined: these ports and all CRC logic are absent.

Test Plan:
- H_ACTIVE=16, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, en=1 -> de high 16 clocks per line, 4 lines per frame. Frame period 154 clocks. href high 2 clocks starting 18 clocks after the de rise. frame_cnt=1 after frame 1.
- Same timing, mode=0 -> pixels 0,1 = 0xFFFFFF; 2,3 = 0xFFFF00; …; 14,15 = 0x000000. data=0 outside de.
- mode=3 -> on line 2, pixel 5 of frame 3 (frame_cnt=2), data=0x020205. Change mode to 2 mid-frame -> pattern switches only at the next frame's first de.
- en dropped at line 1 -> the remaining lines of the frame are still emitted; afterwards de, vsync and href stay inactive and frame_cnt is frozen. Re-assert en -> the new frame starts at 0,0.
- rst pulsed at pixel 7 of line 2 -> next clock de=0, data=0, frame_cnt unchanged from its pre-frame value. Restart produces an intact frame.
- With VIDEO_PATTERN_GEN_CRC_EN, mode=2, CHECK_SIZE=4 -> crc_valid pulses once per 154 clocks. crc_out equals the bench's software CRC of 64 pixels and is identical across frames.
